// File: rtl/banco_registradores.sv
//------------------------------------------------------------------------------
// Module: banco_registradores
//
// Purpose:
//   32 x 32-bit MIPS register file. It sits directly downstream of the
//   write-register address mux. It provides:
//     - two combinational read ports (rs and rt),
//     - one synchronous write port, addressed by the mux's endereco_escrita,
//     - a handshaked debug dump sequencer that streams every register, in
//       index order, to a monitor/display.
//   Register 0 is hardwired to zero. Writes to it are discarded, so a mux
//   select of 0 means "no write".
//
// Parameters:
//   LARGURA_DADOS     data width of each register
//   LARGURA_ENDERECO  address width; register count = 2**LARGURA_ENDERECO
//
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   asynchronous, active-high reset
//   endereco_1        in   read address A (R[s])
//   endereco_2        in   read address B (R[t])
//   endereco_escrita  in   write address, from the write-register mux
//   dado_escrita      in   write data
//   escrita_reg       in   write enable, from the controller
//   dado_1            out  R[endereco_1], combinational
//   dado_2            out  R[endereco_2], combinational
//   dump_inicio       in   start-dump request, sampled on clock
//   dump_pronto       in   consumer ready
//   dump_valido       out  dump word valid
//   dump_endereco     out  index of the word being presented
//   dump_dado         out  value of the word being presented
//   dump_ocupado      out  high while a dump is in progress
//------------------------------------------------------------------------------
module banco_registradores #(
    parameter int LARGURA_DADOS    = 32,
    parameter int LARGURA_ENDERECO = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [LARGURA_ENDERECO-1:0] endereco_1,
    input  logic [LARGURA_ENDERECO-1:0] endereco_2,
    input  logic [LARGURA_ENDERECO-1:0] endereco_escrita,
    input  logic [LARGURA_DADOS-1:0]    dado_escrita,
    input  logic                        escrita_reg,
    output logic [LARGURA_DADOS-1:0]    dado_1,
    output logic [LARGURA_DADOS-1:0]    dado_2,
    input  logic                        dump_inicio,
    input  logic                        dump_pronto,
    output logic                        dump_valido,
    output logic [LARGURA_ENDERECO-1:0] dump_endereco,
    output logic [LARGURA_DADOS-1:0]    dump_dado,
    output logic                        dump_ocupado
);

    localparam int NUM_REGS = 2 ** LARGURA_ENDERECO;
    localparam logic [LARGURA_ENDERECO-1:0] ULTIMO_INDICE = '1;

    typedef enum logic {
        OCIOSO   = 1'b0,
        ENVIANDO = 1'b1
    } estado_t;

    logic [LARGURA_DADOS-1:0]    regs_q [NUM_REGS];
    logic                        escritaValida;

    estado_t                     estado_q, estado_d;
    logic [LARGURA_ENDERECO-1:0] idx_q, idx_d;
    logic [LARGURA_DADOS-1:0]    dumpDado_q, dumpDado_d;
    logic                        dumpValido_q, dumpValido_d;
    logic [LARGURA_ENDERECO-1:0] idxProximo;

    // A write to address 0 is the mux's "no write" encoding, so it is
    // filtered here rather than relying on the controller to drop the enable.
    assign escritaValida = escrita_reg && (endereco_escrita != '0);

    // Register array. Entry 0 is cleared on reset and is never written
    // afterwards, so it stays zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (escritaValida) begin
            regs_q[endereco_escrita] <= dado_escrita;
        end
    end

    // Read ports are plain muxes over the registered array. There is no
    // write-to-read bypass: a read of the address being written this cycle
    // returns the old contents. Address 0 is forced to zero explicitly so
    // the read path never depends on entry 0's storage.
    always_comb begin
        dado_1 = '0;
        dado_2 = '0;
        if (endereco_1 != '0) begin
            dado_1 = regs_q[endereco_1];
        end
        if (endereco_2 != '0) begin
            dado_2 = regs_q[endereco_2];
        end
    end

    // Dump sequencer state. Everything here resets asynchronously, so a
    // reset in the middle of a dump drops valid/busy immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            idx_q        <= '0;
            dumpDado_q   <= '0;
            dumpValido_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            idx_q        <= idx_d;
            dumpDado_q   <= dumpDado_d;
            dumpValido_q <= dumpValido_d;
        end
    end

    assign idxProximo = idx_q + {{(LARGURA_ENDERECO-1){1'b0}}, 1'b1};

    // Next-state logic for the dump. Each word is captured from regs_q when
    // it is loaded. regs_q still holds its pre-edge contents at that point,
    // so a write on the same edge as a load is not seen by that load. Later
    // writes to the word on display do not disturb dump_dado. Words not yet
    // loaded pick up any write made before their own load edge. A start
    // request while a dump is already running is ignored.
    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        dumpDado_d   = dumpDado_q;
        dumpValido_d = dumpValido_q;

        unique case (estado_q)
            OCIOSO: begin
                if (dump_inicio) begin
                    estado_d     = ENVIANDO;
                    idx_d        = '0;
                    dumpDado_d   = regs_q[0];
                    dumpValido_d = 1'b1;
                end
            end

            ENVIANDO: begin
                if (dump_pronto) begin
                    if (idx_q == ULTIMO_INDICE) begin
                        // Final word accepted: go idle and return the
                        // presentation registers to their reset values.
                        estado_d     = OCIOSO;
                        idx_d        = '0;
                        dumpDado_d   = '0;
                        dumpValido_d = 1'b0;
                    end else begin
                        idx_d      = idxProximo;
                        dumpDado_d = regs_q[idxProximo];
                    end
                end
            end

            default: begin
                estado_d     = OCIOSO;
                dumpValido_d = 1'b0;
            end
        endcase
    end

    assign dump_valido   = dumpValido_q;
    assign dump_endereco = idx_q;
    assign dump_dado     = dumpDado_q;
    assign dump_ocupado  = (estado_q == ENVIANDO);

endmodule

// File: tb/tb_banco_registradores.sv
//------------------------------------------------------------------------------
// Testbench: tb_banco_registradores
//
// Purpose:
//   Self-checking bench for banco_registradores. A behavioural model holds
//   the register contents as a plain array and tracks the dump as "which
//   word is on display and what it held when loaded". Directed scenarios
//   cover reset, the write/read rules and the dump handshake. A randomized
//   phase follows, and the bench ends with a reset applied mid-dump.
//------------------------------------------------------------------------------
module tb_banco_registradores;

    logic        clock;
    logic        reset;
    logic [4:0]  endereco_1;
    logic [4:0]  endereco_2;
    logic [4:0]  endereco_escrita;
    logic [31:0] dado_escrita;
    logic        escrita_reg;
    logic [31:0] dado_1;
    logic [31:0] dado_2;
    logic        dump_inicio;
    logic        dump_pronto;
    logic        dump_valido;
    logic [4:0]  dump_endereco;
    logic [31:0] dump_dado;
    logic        dump_ocupado;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mem [32];
    bit          mBusy;
    int          mIdx;
    logic [31:0] mWord;

    banco_registradores #(
        .LARGURA_DADOS   (32),
        .LARGURA_ENDERECO(5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .endereco_1      (endereco_1),
        .endereco_2      (endereco_2),
        .endereco_escrita(endereco_escrita),
        .dado_escrita    (dado_escrita),
        .escrita_reg     (escrita_reg),
        .dado_1          (dado_1),
        .dado_2          (dado_2),
        .dump_inicio     (dump_inicio),
        .dump_pronto     (dump_pronto),
        .dump_valido     (dump_valido),
        .dump_endereco   (dump_endereco),
        .dump_dado       (dump_dado),
        .dump_ocupado    (dump_ocupado)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: count it, and report and count it on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Bring the model back to its power-on state
    task automatic modelReset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mBusy = 1'b0;
        mIdx  = 0;
        mWord = 32'h0;
    endtask

    // Advance the model across one rising edge. The dump sees the register
    // contents as they were before the edge, then the write lands.
    task automatic modelEdge();
        if (!mBusy) begin
            if (dump_inicio) begin
                mBusy = 1'b1;
                mIdx  = 0;
                mWord = mem[0];
            end
        end else if (dump_pronto) begin
            if (mIdx == 31) begin
                mBusy = 1'b0;
            end else begin
                mIdx  = mIdx + 1;
                mWord = mem[mIdx];
            end
        end
        if (escrita_reg && endereco_escrita != 5'd0)
            mem[endereco_escrita] = dado_escrita;
    endtask

    // Drive one cycle of inputs on the falling edge and check the read ports
    // before the rising edge. Then step the model and check the dump outputs
    // just after the edge.
    task automatic applyStimulus(input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] a1,
                                 input logic [4:0] a2, input logic ini,
                                 input logic rdy);
        @(negedge clock);
        escrita_reg      = we;
        endereco_escrita = wa;
        dado_escrita     = wd;
        endereco_1       = a1;
        endereco_2       = a2;
        dump_inicio      = ini;
        dump_pronto      = rdy;
        #1;
        checkOutput("read1", dado_1, mem[a1]);
        checkOutput("read2", dado_2, mem[a2]);
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput("dumpValido", {31'h0, dump_valido}, {31'h0, mBusy});
        checkOutput("dumpOcupado", {31'h0, dump_ocupado}, {31'h0, mBusy});
        if (mBusy) begin
            checkOutput("dumpEndereco", {27'h0, dump_endereco}, mIdx);
            checkOutput("dumpDado", dump_dado, mWord);
        end
    endtask

    // Asynchronous reset between clock edges, then sweep every address
    task automatic resetCheck(input string tag);
        @(negedge clock);
        escrita_reg = 1'b0;
        dump_inicio = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, "Valido"}, {31'h0, dump_valido}, 32'h0);
        checkOutput({tag, "Ocupado"}, {31'h0, dump_ocupado}, 32'h0);
        checkOutput({tag, "Endereco"}, {27'h0, dump_endereco}, 32'h0);
        checkOutput({tag, "Dado"}, dump_dado, 32'h0);
        for (int i = 0; i < 32; i++) begin
            endereco_1 = 5'(i);
            endereco_2 = 5'(31 - i);
            #1;
            checkOutput({tag, "Read1"}, dado_1, 32'h0);
            checkOutput({tag, "Read2"}, dado_2, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int waitCount;

        reset            = 1'b1;
        escrita_reg      = 1'b0;
        endereco_escrita = 5'd0;
        dado_escrita     = 32'h0;
        endereco_1       = 5'd0;
        endereco_2       = 5'd0;
        dump_inicio      = 1'b0;
        dump_pronto      = 1'b0;
        modelReset();

        // Power-on reset state
        #1;
        checkOutput("rstValido", {31'h0, dump_valido}, 32'h0);
        checkOutput("rstOcupado", {31'h0, dump_ocupado}, 32'h0);
        checkOutput("rstDado1", dado_1, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Write R5 with no bypass: old value in the write cycle, new value after
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 1'b0);
        checkOutput("r5New", dado_1, 32'hDEADBEEF);

        // A write to R0 is discarded
        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("r0Zero", dado_1, 32'h0);

        // A write with the enable low leaves R7 unchanged
        applyStimulus(1'b1, 5'd7, 32'h00000077, 5'd7, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd0, 1'b0, 1'b0);
        checkOutput("r7Kept", dado_1, 32'h00000077);

        // Preload R[i] = i*3, then a full dump with ready held high
        for (int i = 1; i < 32; i++)
            applyStimulus(1'b1, 5'(i), 32'(i * 3), 5'(i - 1), 5'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b1, 1'b1);
        checkOutput("fullIdx0", {27'h0, dump_endereco}, 32'd0);
        checkOutput("fullDado0", dump_dado, 32'd0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'd0, 1'b0, 1'b1);
            checkOutput("fullValid", {31'h0, dump_valido}, 32'd1);
            checkOutput("fullIdx", {27'h0, dump_endereco}, 32'(i));
            checkOutput("fullDado", dump_dado, 32'(i * 3));
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("fullEndValido", {31'h0, dump_valido}, 32'd0);
        checkOutput("fullEndOcupado", {31'h0, dump_ocupado}, 32'd0);

        // Stall at idx 4 while R4/R5 are written and a restart is requested
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b1);
        checkOutput("stallIdx", {27'h0, dump_endereco}, 32'd4);
        applyStimulus(1'b1, 5'd4, 32'hAAAA0000, 5'd4, 5'd5, 1'b0, 1'b0);
        checkOutput("stallHold1", dump_dado, 32'd12);
        applyStimulus(1'b1, 5'd5, 32'h00005555, 5'd4, 5'd5, 1'b0, 1'b0);
        checkOutput("stallHold2", dump_dado, 32'd12);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b1, 1'b0);
        checkOutput("stallNoRestart", {27'h0, dump_endereco}, 32'd4);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b0);
        checkOutput("stallHold5", dump_dado, 32'd12);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b1);
        checkOutput("releaseIdx", {27'h0, dump_endereco}, 32'd5);
        checkOutput("releaseDado", dump_dado, 32'h00005555);
        waitCount = 0;
        while (mBusy && waitCount < 40) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b1);
            waitCount++;
        end
        checkOutput("drainDone", {31'h0, dump_ocupado}, 32'd0);

        // Randomized traffic: writes, reads and dumps with an erratic consumer
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom(), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 2) != 0));
        end

        // Reset in the middle of a dump with registers holding data
        for (int i = 1; i < 32; i++)
            applyStimulus(1'b1, 5'(i), $urandom() | 32'h1, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("preResetBusy", {31'h0, dump_ocupado}, 32'd1);
        resetCheck("midReset");
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd17, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
